// File: rtl/ret_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack_pkg
//  Description : Shared constants and types for the return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
package ret_stack_pkg;

    localparam int PC_WIDTH = 10;
    localparam int RS_DEPTH = 8;

    // Encodings follow {push, pop} so the decode is a straight cast.
    typedef enum logic [1:0] {
        RS_NOP  = 2'b00,
        RS_PUSH = 2'b10,
        RS_POP  = 2'b01,
        RS_SWAP = 2'b11
    } rs_op_e;

    typedef enum logic [1:0] {
        RS_EMPTY   = 2'd0,
        RS_PARTIAL = 2'd1,
        RS_FULL    = 2'd2
    } rs_occ_e;

    function automatic rs_op_e rs_decode(input logic push, input logic pop);
        return rs_op_e'({push, pop});
    endfunction

endpackage
`default_nettype wire

// File: rtl/ret_stack_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack_mem
//  Description : DEPTH x WIDTH register array, one synchronous write port and
//                one asynchronous read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack_mem
    import ret_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = RS_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : LIFO return-address stack with occupancy tracking and a
//                sticky overflow/underflow flag. Build option
//                RET_STACK_WRAP_EN makes a push on a full stack overwrite the
//                oldest entry instead of being dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = RS_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_COUNT_W = $clog2(DEPTH+1);

    logic [c_ADDR_W-1:0]  r_top;
    logic [c_COUNT_W-1:0] r_count;
    logic                 r_err;

    rs_op_e               w_op;
    rs_occ_e              w_occ;
    logic [c_ADDR_W-1:0]  w_top_inc;
    logic [c_ADDR_W-1:0]  w_top_dec;
    logic [c_ADDR_W-1:0]  w_top_nxt;
    logic [c_COUNT_W-1:0] w_count_nxt;
    logic                 w_we;
    logic [c_ADDR_W-1:0]  w_waddr;
    logic                 w_err_set;
    logic [WIDTH-1:0]     w_rdata;

    assign w_op = rs_decode(push, pop);

    always_comb begin
        if (r_count == '0) begin
            w_occ = RS_EMPTY;
        end else if (r_count == c_COUNT_W'(DEPTH)) begin
            w_occ = RS_FULL;
        end else begin
            w_occ = RS_PARTIAL;
        end
    end

    // DEPTH is a power of two, so natural wrap of the pointer is mod DEPTH.
    assign w_top_inc = r_top + c_ADDR_W'(1);
    assign w_top_dec = r_top - c_ADDR_W'(1);

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_top;
        w_top_nxt   = r_top;
        w_count_nxt = r_count;
        w_err_set   = 1'b0;
        case (w_op)
            RS_PUSH: begin
                if (w_occ != RS_FULL) begin
                    w_we        = 1'b1;
                    w_top_nxt   = w_top_inc;
                    w_count_nxt = r_count + c_COUNT_W'(1);
                end else begin
`ifdef RET_STACK_WRAP_EN
                    // Oldest entry sits at top when full; overwrite it.
                    w_we      = 1'b1;
                    w_top_nxt = w_top_inc;
`else
                    w_err_set = 1'b1;
`endif
                end
            end
            RS_POP: begin
                if (w_occ != RS_EMPTY) begin
                    w_top_nxt   = w_top_dec;
                    w_count_nxt = r_count - c_COUNT_W'(1);
                end else begin
                    w_err_set = 1'b1;
                end
            end
            RS_SWAP: begin
                if (w_occ != RS_EMPTY) begin
                    w_we    = 1'b1;
                    w_waddr = w_top_dec;
                end else begin
                    // Return with nothing to return to: still honour the call.
                    w_we        = 1'b1;
                    w_top_nxt   = w_top_inc;
                    w_count_nxt = r_count + c_COUNT_W'(1);
                    w_err_set   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_top   <= w_top_nxt;
            r_count <= w_count_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    ret_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we & ~reset),
        .waddr (w_waddr),
        .wdata (din),
        .raddr (w_top_dec),
        .rdata (w_rdata)
    );

    assign dout  = (w_occ == RS_EMPTY) ? '0 : w_rdata;
    assign empty = (w_occ == RS_EMPTY);
    assign full  = (w_occ == RS_FULL);
    assign count = r_count;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ret_stack
//  Description : Directed self-checking bench for ret_stack; expected state is
//                queued when a step is driven and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ret_stack;

    localparam int W = 10;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset, push, pop;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         empty, full, err;
    logic [3:0]   count;

    typedef struct {
        logic [3:0]   count;
        logic [W-1:0] dout;
        logic         empty;
        logic         full;
        logic         err;
        string        tag;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    ret_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check_one();
        exp_t e;
        n_total++;
        assert (q.size() > 0) n_pass++;
        else $error("FAIL scoreboard_empty observed=%0d required=1", q.size());
        if (q.size() == 0) return;
        e = q.pop_front();
        n_total++;
        assert (count === e.count) n_pass++;
        else $error("FAIL %s count observed=%0d required=%0d", e.tag, count, e.count);
        n_total++;
        assert (dout === e.dout) n_pass++;
        else $error("FAIL %s dout observed=0x%03h required=0x%03h", e.tag, dout, e.dout);
        n_total++;
        assert (empty === e.empty) n_pass++;
        else $error("FAIL %s empty observed=%b required=%b", e.tag, empty, e.empty);
        n_total++;
        assert (full === e.full) n_pass++;
        else $error("FAIL %s full observed=%b required=%b", e.tag, full, e.full);
        n_total++;
        assert (err === e.err) n_pass++;
        else $error("FAIL %s err observed=%b required=%b", e.tag, err, e.err);
    endtask

    // Drive one cycle, queue the expected post-edge state, then compare.
    task automatic step(input string tag, input logic r, input logic pu, input logic po,
                        input logic [W-1:0] d, input int c, input logic [W-1:0] o,
                        input logic e);
        exp_t x;
        @(negedge clk);
        reset = r; push = pu; pop = po; din = d;
        x.count = 4'(c);
        x.dout  = o;
        x.empty = (c == 0);
        x.full  = (c == D);
        x.err   = e;
        x.tag   = tag;
        q.push_back(x);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;

        step("reset",      1, 0, 0, 10'h000, 0, 10'h000, 0);
        step("idle",       0, 0, 0, 10'h000, 0, 10'h000, 0);

        step("push1",      0, 1, 0, 10'h005, 1, 10'h005, 0);
        step("push2",      0, 1, 0, 10'h012, 2, 10'h012, 0);
        step("push3",      0, 1, 0, 10'h3FF, 3, 10'h3FF, 0);
        step("pop1",       0, 0, 1, 10'h000, 2, 10'h012, 0);
        step("pop2",       0, 0, 1, 10'h000, 1, 10'h005, 0);
        step("pop3",       0, 0, 1, 10'h000, 0, 10'h000, 0);

        step("pop_empty",  0, 0, 1, 10'h000, 0, 10'h000, 1);
        step("err_sticky", 0, 0, 0, 10'h000, 0, 10'h000, 1);
        step("err_clear",  1, 0, 0, 10'h000, 0, 10'h000, 0);

        for (int i = 1; i <= D; i++)
            step("fill", 0, 1, 0, W'(i), i, W'(i), 0);
`ifdef RET_STACK_WRAP_EN
        step("push_full",  0, 1, 0, 10'h009, D, 10'h009, 0);
        for (int k = 1; k <= D; k++)
            step("drain", 0, 0, 1, 10'h000, D - k, (k == D) ? 10'h000 : W'(9 - k), 0);
`else
        step("push_full",  0, 1, 0, 10'h009, D, 10'h008, 1);
        for (int k = 1; k <= D; k++)
            step("drain", 0, 0, 1, 10'h000, D - k, W'(D - k), 1);
`endif
        step("reset2",     1, 0, 0, 10'h000, 0, 10'h000, 0);

        step("push_a0",    0, 1, 0, 10'h0A0, 1, 10'h0A0, 0);
        step("swap_b0",    0, 1, 1, 10'h0B0, 1, 10'h0B0, 0);
        step("pop_b0",     0, 0, 1, 10'h000, 0, 10'h000, 0);
        step("swap_empty", 0, 1, 1, 10'h0C0, 1, 10'h0C0, 1);
        step("reset3",     1, 0, 0, 10'h000, 0, 10'h000, 0);

        for (int i = 1; i <= D; i++)
            step("fill2", 0, 1, 0, W'(i + 16), i, W'(i + 16), 0);
        step("swap_full",  0, 1, 1, 10'h055, D, 10'h055, 0);
        step("pop_after_swap", 0, 0, 1, 10'h000, D - 1, 10'h017, 0);
        step("reset4",     1, 0, 0, 10'h000, 0, 10'h000, 0);

        step("push_111",   0, 1, 0, 10'h111, 1, 10'h111, 0);
        step("push_222",   0, 1, 0, 10'h222, 2, 10'h222, 0);
        step("reset_push", 1, 1, 0, 10'h333, 0, 10'h000, 0);
        step("post_reset", 0, 0, 0, 10'h000, 0, 10'h000, 0);
        step("push_after", 0, 1, 0, 10'h044, 1, 10'h044, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ret_stack.md
# ret_stack

Return-address stack for the single-cycle control unit. On a subroutine call it captures the incremented PC (output of the PC adder) and, on a return, presents the saved address to the PC-source multiplexer in front of the PC register. It sits directly upstream of the PC register and mux, alongside the PC+1 adder. It is a LIFO with occupancy tracking and a sticky error flag.

## Interface
Parameters:
- WIDTH, 10, address width; matches the PC/adder width.
- DEPTH, 8, number of entries; power of two, at least 2.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- push  in  1  call: store din as the new top.
- pop  in  1  return: discard the top.
- din  in  WIDTH  return address (PC+1).
- dout  out  WIDTH  current top entry; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- err  out  1  sticky overflow/underflow flag; cleared only by reset.

## Operation
- Storage is a ring of DEPTH entries.
  - top: pointer to the next free slot.
  - count: number of valid entries.
  - Occupancy state is derived from count: EMPTY (0), PARTIAL, FULL (DEPTH).
- The (push, pop) pair decodes to one operation per cycle:
  - 00 NOP: no change.
  - 10 PUSH, not full: mem[top] <= din; top <= top+1 mod DEPTH; count <= count+1.
  - 01 POP, not empty: top <= top-1 mod DEPTH; count <= count-1. Stored data is untouched.
  - 11 SWAP, not empty: mem[top-1] <= din; top and count unchanged. This is a return immediately followed by a call.
- Boundary cases:
  - POP when EMPTY: no state change except err <= 1; dout stays 0.
  - SWAP when EMPTY: executed as PUSH (count becomes 1) and err <= 1.
  - PUSH when FULL: behaviour depends on the macro (see Configuration).
  - SWAP when FULL: legal and ordinary; no error.
- dout = mem[top-1 mod DEPTH] when count != 0, else 0.
- Pointer arithmetic is modulo DEPTH. count never exceeds DEPTH and never underflows.

## Timing
- Reset values: count=0, top=0, err=0, empty=1, full=0, dout=0. Storage contents are not reset.
- Reset takes priority over push and pop in the same cycle.
- Reset asserted mid-operation discards all entries on that edge.
- Operations take one cycle. push and pop are sampled on a clock edge, and the new dout, count, empty and full are valid immediately after that edge.
- dout is combinational from storage and pointers. There is no path from din to dout within the same cycle, so a SWAP shows the new top only after the edge.
- err is asserted starting the cycle after the offending edge and holds until reset.
- No handshake: the control unit guarantees push and pop are single-cycle strobes derived from the decoded opcode.

## Configuration
Macro RET_STACK_WRAP_EN.
- Defined: PUSH when FULL overwrites the oldest entry.
  - mem[top] <= din; top advances; count stays DEPTH; err is not set.
  - This gives bounded recursion that silently loses the deepest return addresses.
- Undefined: PUSH when FULL is ignored.
  - Storage, top and count are unchanged; err <= 1.
- Underflow handling is identical in both builds.

## Structure
- Shared package ret_stack_pkg holds:
  - PC_WIDTH = 10 and RS_DEPTH = 8 constants, used as parameter defaults.
  - Enumerated op type {RS_NOP, RS_PUSH, RS_POP, RS_SWAP} decoded from {push, pop}.
- Sub-module ret_stack_mem: DEPTH×WIDTH register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset.
- Top level holds the pointer/count logic, op decode, the err flag and the dout zero-gating.

## Test plan
- Reset, then hold idle: count=0, empty=1, full=0, dout=0, err=0.
- PUSH 0x005, then 0x012, then 0x3FF: count=3 and dout=0x3FF. Three POPs: dout reads 0x012, then 0x005, then 0 with empty=1; err stays 0.
- POP on an empty stack: err=1, count=0. A following reset clears err.
- PUSH 0x001..0x008 (8 pushes, full=1), then PUSH 0x009:
  - Without macro: count=8, dout=0x008, err=1.
  - With macro: count=8, dout=0x009, err=0. Eight POPs then yield 0x009 down to 0x002.
- PUSH 0x0A0, then SWAP with din=0x0B0: count=1, dout=0x0B0. SWAP on empty: count=1, err=1.
- PUSH 0x111, 0x222, then assert reset together with push=1 and din=0x333: count=0, dout=0, empty=1.
